// File: rtl/mult_c3x2_scheduler.sv
// Two-requester round-robin front end for the C3x2 27x18 multiplier.
// S1 holds the operands driving the multiplier; S2 holds the combined response.
module mult_c3x2_scheduler (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [223:0] req_op,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic         rsp_err,
    output logic [47:0]  rsp_data,
    output logic [53:0]  mul_a,
    output logic [53:0]  mul_b,
    output logic         mul_a_sign,
    output logic         mul_b_sign,
    output logic [1:0]   mul_mode,
    input  logic [44:0]  mul_result_0,
    input  logic [44:0]  mul_result_1,
    input  logic [3:0]   mul_sidm_carry
);

    typedef enum logic [1:0] {
        MODE_27X18 = 2'b00,
        MODE_SIDM  = 2'b01,
        MODE_RSV2  = 2'b10,
        MODE_RSV3  = 2'b11
    } mode_e;

    logic         s1_v_q, s1_v_d;
    logic [111:0] s1_op_q, s1_op_d;
    logic         s1_id_q, s1_id_d;
    logic         rr_last_q, rr_last_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic         rsp_id_q, rsp_id_d;
    logic         rsp_err_q, rsp_err_d;
    logic [47:0]  rsp_data_q, rsp_data_d;

    logic [1:0]   grant;
    logic         s2_acc, s1_acc;
    logic         hs, hs_id;
    mode_e        s1_mode;
    logic         s1_rsv;
    logic         s1_a_sign, s1_b_sign;
    logic [44:0]  sum45;
    logic [28:0]  lo_sum;
    logic [19:0]  lo, hi;
    logic [47:0]  comb_data;

    // On a tie the requester that lost the previous handshake wins.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign s2_acc    = !rsp_valid_q || rsp_ready;
    assign s1_acc    = !s1_v_q || s2_acc;
    assign req_ready = reset ? 2'b00 : (grant & {2{s1_acc}});
    assign hs        = |(req_valid & req_ready);
    assign hs_id     = req_ready[1];

    assign s1_mode   = mode_e'(s1_op_q[111:110]);
    assign s1_rsv    = (s1_mode == MODE_RSV2) || (s1_mode == MODE_RSV3);
    assign s1_a_sign = s1_op_q[109];
    assign s1_b_sign = s1_op_q[108];

    // Reserved ops still occupy the pipeline but present an idle multiplier.
    always_comb begin
        mul_a      = '0;
        mul_b      = '0;
        mul_a_sign = 1'b0;
        mul_b_sign = 1'b0;
        mul_mode   = MODE_27X18;
        if (s1_v_q && !s1_rsv) begin
            mul_mode   = s1_op_q[111:110];
            mul_a_sign = s1_a_sign;
            mul_b_sign = s1_b_sign;
            mul_a      = s1_op_q[107:54];
            mul_b      = s1_op_q[53:0];
        end
    end

    assign sum45  = mul_result_0 + mul_result_1;
    assign lo_sum = {mul_sidm_carry[1:0], mul_result_0[26:0]} + {2'b00, mul_result_1[26:0]};
    assign lo     = 20'(lo_sum >> 9);
    assign hi     = {mul_sidm_carry[3:2], mul_result_0[44:27]} + {2'b00, mul_result_1[44:27]};

    always_comb begin
        comb_data = '0;
        case (s1_mode)
            MODE_27X18: comb_data = (s1_a_sign || s1_b_sign) ? {{3{sum45[44]}}, sum45}
                                                             : {3'b000, sum45};
            MODE_SIDM:  comb_data = {8'h00, hi, lo};
            default:    comb_data = '0;
        endcase
    end

    always_comb begin
        s1_v_d      = s1_v_q;
        s1_op_d     = s1_op_q;
        s1_id_d     = s1_id_q;
        rr_last_d   = rr_last_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;

        // A new handshake overrides the drain of S1 in the same cycle.
        if (hs) begin
            s1_v_d    = 1'b1;
            s1_op_d   = hs_id ? req_op[223:112] : req_op[111:0];
            s1_id_d   = hs_id;
            rr_last_d = hs_id;
        end else if (s2_acc) begin
            s1_v_d = 1'b0;
        end

        if (s1_v_q && s2_acc) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = s1_id_q;
            rsp_err_d   = s1_rsv;
            rsp_data_d  = comb_data;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_v_q      <= 1'b0;
            s1_op_q     <= '0;
            s1_id_q     <= 1'b0;
            rr_last_q   <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_op_q     <= s1_op_d;
            s1_id_q     <= s1_id_d;
            rr_last_q   <= rr_last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;

endmodule
